// File: rtl/config_readback.sv
// Config latch bank read-back: single-row capture and XOR-fold sweep.
// Ports: register window (write_req/read_req/address/data_in/data_out/data_valid), row mux (row_sel/row_data), busy.
module config_readback #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 64,
  parameter int SETTLE = 1,
  localparam int IDX_BITS = DEPTH > 16 ? 5 : DEPTH > 8 ? 4 : 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_req,
  input  logic                read_req,
  input  logic [2:0]          address,
  input  logic [31:0]         data_in,
  input  logic [WIDTH-1:0]    row_data,
  output logic [IDX_BITS-1:0] row_sel,
  output logic [31:0]         data_out,
  output logic                data_valid,
  output logic                busy
);

  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    CAPTURE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic             sweep;
  logic             captured;
  logic             err;
  logic [WIDTH-1:0] cap;
  logic [31:0]      checksum;
  logic [31:0]      rd_mux;
  logic             capture_en;

  logic wr_row;
  logic wr_sweep;
  logic start_req;
  logic row_ok;
  logic go;
  logic done;

  logic [63:0] row_ext;
  logic [63:0] cap_ext;

  assign wr_row    = write_req && (address == 3'd5);
  assign wr_sweep  = write_req && (address == 3'd6);
  assign start_req = wr_row || wr_sweep;
  assign row_ok    = data_in < 32'(DEPTH);
  assign go        = start_req && (state == IDLE) && (wr_sweep || row_ok);
  // Last capture of an operation: a single read, or the sweep reaching row 0.
  assign done      = !sweep || (row_sel == '0);
  assign row_ext   = 64'(row_data);
  assign cap_ext   = 64'(cap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = SELECT;
      SELECT:  if (cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = done ? IDLE : SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    capture_en = (state == CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sel  <= '0;
      cnt      <= '0;
      sweep    <= 1'b0;
      captured <= 1'b0;
      cap      <= '0;
      checksum <= '0;
    end else if (go) begin
      sweep    <= wr_sweep;
      row_sel  <= wr_sweep ? LAST : data_in[IDX_BITS-1:0];
      cnt      <= CNT_INIT;
      captured <= 1'b0;
      if (wr_sweep) checksum <= '0;
    end else if (state == SELECT) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end else if (capture_en) begin
      cap <= row_data;
      cnt <= CNT_INIT;
      if (sweep)
        checksum <= checksum ^ row_ext[31:0] ^ row_ext[63:32];
      if (done) captured <= 1'b1;
      else      row_sel  <= row_sel - 1'b1;
    end
  end

  // Any refused start (busy or bad row) flags err; an accepted one clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (go)        err <= 1'b0;
    else if (start_req) err <= 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      3'd0:    rd_mux = cap_ext[31:0];
      3'd4:    rd_mux = cap_ext[63:32];
      3'd5:    rd_mux = {24'b0, busy, captured, err, 5'(row_sel)};
      3'd6:    rd_mux = checksum;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= read_req;
      if (read_req) data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_config_readback.sv
// Directed bench for config_readback.
// Main instance uses defaults; a second instance runs with SETTLE=3.
module tb_config_readback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_req = 1'b0;
  logic        read_req = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [63:0] row_data;
  logic [2:0]  row_sel;
  logic [31:0] data_out;
  logic        data_valid;
  logic        busy;
  logic [63:0] rows [8];

  logic        wr6 = 1'b0;
  logic        rd6 = 1'b0;
  logic [2:0]  addr6 = '0;
  logic [31:0] din6 = '0;
  logic [63:0] row6 = '0;
  logic [2:0]  sel6;
  logic [31:0] dout6;
  logic        dv6;
  logic        busy6;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign row_data = rows[row_sel];

  config_readback u_dut (
    .clk(clk), .rst_n(rst_n), .write_req(write_req),
    .read_req(read_req), .address(address),
    .data_in(data_in), .row_data(row_data),
    .row_sel(row_sel), .data_out(data_out),
    .data_valid(data_valid), .busy(busy)
  );

  config_readback #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .write_req(wr6),
    .read_req(rd6), .address(addr6),
    .data_in(din6), .row_data(row6),
    .row_sel(sel6), .data_out(dout6),
    .data_valid(dv6), .busy(busy6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write_req = 1'b1;
    address   = a;
    data_in   = d;
    tick();
    write_req = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                    input string name);
    read_req = 1'b1;
    address  = a;
    tick();
    read_req = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h valid=%b, want %h valid=1",
               name, data_out, data_valid, exp);
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    for (int i = 0; i < 8; i++) rows[i] = {32'h0, 32'h1 << i};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({busy, data_valid, row_sel, data_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b dv=%b sel=%0d dout=%h, want 0",
               busy, data_valid, row_sel, data_out);
    end
    wr(3'd6, 32'h0);
    for (n = 0; n < 4; n++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, data_valid, row_sel, data_out, busy6} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b dv=%b sel=%0d dout=%h, want 0",
               busy, data_valid, row_sel, data_out);
    end
    tick();
    rst_n = 1'b1;
    rd(3'd6, 32'h0, "reset_checksum");
    rd(3'd0, 32'h0, "reset_buf");
    rd(3'd5, 32'h0, "reset_status");
  endtask

  task automatic test_single();
    int n;
    rows[3] = 64'hDEAD_BEEF_0123_4567;
    wr(3'd5, 32'd3);
    busy_len(n);
    n_cmp++;
    if (n !== 2) begin
      n_bad++;
      $display("FAIL single_busy: got %0d cycles, want 2", n);
    end
    rd(3'd0, 32'h0123_4567, "single_lo");
    rd(3'd4, 32'hDEAD_BEEF, "single_hi");
    rd(3'd5, 32'h43, "single_status");
    rd(3'd3, 32'h0, "unmapped_addr");
  endtask

  task automatic test_sweep();
    int n;
    for (int i = 0; i < 8; i++) rows[i] = {32'h0, 32'h1 << i};
    wr(3'd6, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n_cmp++;
      if (row_sel !== 3'(7 - n / 2)) begin
        n_bad++;
        $display("FAIL sweep_row_sel[%0d]: got %0d, want %0d",
                 n, row_sel, 7 - n / 2);
      end
      n++;
      tick();
    end
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL sweep_busy: got %0d cycles, want 16", n);
    end
    rd(3'd6, 32'h0000_00FF, "sweep_checksum");
    rd(3'd0, 32'h1, "sweep_buf_row0");
    rd(3'd4, 32'h0, "sweep_buf_hi");
  endtask

  task automatic test_bad_row();
    int n;
    wr(3'd5, 32'd9);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_row_busy: got %b, want 0", busy);
    end
    rd(3'd5, 32'h60, "bad_row_status");
    // Read and write together: read sees pre-write status.
    read_req  = 1'b1;
    write_req = 1'b1;
    address   = 3'd5;
    data_in   = 32'd2;
    tick();
    read_req  = 1'b0;
    write_req = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 32'h60) begin
      n_bad++;
      $display("FAIL rd_wr_same_cycle: got %h, want 00000060", data_out);
    end
    busy_len(n);
    n_cmp++;
    if (n !== 2) begin
      n_bad++;
      $display("FAIL err_clear_busy: got %0d, want 2", n);
    end
    rd(3'd5, 32'h42, "err_cleared_status");
  endtask

  task automatic test_back_to_back();
    int n;
    wr(3'd6, 32'h0);
    wr(3'd5, 32'd2);
    rd(3'd5, 32'hA7, "b2b_status_busy");
    busy_len(n);
    n_cmp++;
    if (n !== 14) begin
      n_bad++;
      $display("FAIL b2b_remaining_busy: got %0d, want 14", n);
    end
    rd(3'd6, 32'h0000_00FF, "b2b_checksum");
    rd(3'd5, 32'h60, "b2b_status_end");
  endtask

  task automatic test_settle3();
    logic [63:0] vals [5];
    vals[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    vals[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    vals[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    vals[3] = 64'h1111_2222_3333_4444;
    vals[4] = 64'h5555_6666_7777_8888;
    wr6   = 1'b1;
    addr6 = 3'd5;
    din6  = 32'd1;
    tick();
    wr6 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      row6 = vals[k];
      n_cmp++;
      if (busy6 !== (k < 4) || (k < 3 && sel6 !== 3'd1)) begin
        n_bad++;
        $display("FAIL settle3_cycle%0d: busy=%b sel=%0d, want busy=%b sel=1",
                 k, busy6, sel6, k < 4);
      end
      tick();
    end
    rd6   = 1'b1;
    addr6 = 3'd0;
    tick();
    addr6 = 3'd4;
    n_cmp++;
    if (dv6 !== 1'b1 || dout6 !== 32'h3333_4444) begin
      n_bad++;
      $display("FAIL settle3_lo: got %h, want 33334444", dout6);
    end
    tick();
    rd6 = 1'b0;
    n_cmp++;
    if (dv6 !== 1'b1 || dout6 !== 32'h1111_2222) begin
      n_bad++;
      $display("FAIL settle3_hi: got %h, want 11112222", dout6);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_bad_row();
    test_back_to_back();
    test_settle3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
